// File: rtl/fifo_rdpref.sv
// fifo_rdpref: read-side prefetch stage behind the FIFO controller and its
// synchronous RAM. It pops the controller ahead of demand and captures RAM
// data into a 3-entry skid buffer. Words are presented to the consumer on a
// valid/ready handshake.
// Optional feature macro: FIFO_RDPREF_RDCNT_EN adds the 16-bit delivered-word
// counter output rdcnt.
module fifo_rdpref #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fsh,
  input  logic              notempty,
  output logic              fiford,
  output logic              fifofsh,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              out_vld,
  output logic [DWIDTH-1:0] out_dat,
  input  logic              out_rdy,
  output logic [1:0]        bufcnt
`ifdef FIFO_RDPREF_RDCNT_EN
  ,
  output logic [15:0]       rdcnt
`endif
);

  logic [DWIDTH-1:0] mem_q [3];
  logic [1:0]        wptr_q, wptr_d;
  logic [1:0]        rptr_q, rptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [2:0]        occ_s;
  logic              iss_s;
  logic              cap_s;
  logic              pop_s;

  // Pointers step through 0,1,2 and wrap back to 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : (p + 2'd1);
  endfunction

  // Issue, capture and handshake decode; out_rdy never reaches fiford.
  always_comb begin
    occ_s   = {1'b0, cnt_q} + {2'b00, inflight_q};
    fiford  = notempty & ~fsh & ~rst & (occ_s < 3'd3);
    iss_s   = fiford & notempty;
    cap_s   = inflight_q & ~fsh;
    out_vld = (cnt_q != 2'd0);
    pop_s   = out_vld & out_rdy;
    out_dat = mem_q[rptr_q];
  end

  assign fifofsh = fsh;
  assign bufcnt  = cnt_q;

  // Next-state for pointers, occupancy and the in-flight flag; flush wins.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    inflight_d = iss_s;
    if (fsh) begin
      wptr_d     = 2'd0;
      rptr_d     = 2'd0;
      cnt_d      = 2'd0;
      inflight_d = 1'b0;
    end else begin
      if (cap_s) begin
        wptr_d = ptr_inc(wptr_q);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = ptr_inc(rptr_q);
      end else begin
        rptr_d = rptr_q;
      end
      case ({cap_s, pop_s})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Skid buffer storage: RAM data lands one cycle after an accepted pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else if (cap_s) begin
      mem_q[wptr_q] <= mem_rdata;
    end
  end

`ifdef FIFO_RDPREF_RDCNT_EN
  logic [15:0] rdcnt_q;

  // Delivered-word counter; a flush clears it even if a pop happens too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdcnt_q <= 16'd0;
    end else if (fsh) begin
      rdcnt_q <= 16'd0;
    end else if (pop_s) begin
      rdcnt_q <= rdcnt_q + 16'd1;
    end
  end

  assign rdcnt = rdcnt_q;
`endif

endmodule
